rptr_empty: RTL and testbench

//  Read-side pointer/empty controller of the async FIFO. It is the companion stage to the write

---
 rtl/async_fifo_pkg.sv | 24 ++
 rtl/gray_sync.sv | 30 +++
 rtl/rptr_empty.sv | 95 +++++++++
 tb/tb_rptr_empty.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared helpers for the async FIFO pointer blocks: Gray/binary conversion and synchroniser limits.
// Functions work on a fixed wide word; callers zero-extend narrower pointers and truncate the result.
package async_fifo_pkg;

    localparam int FIFO_SYNC_STAGES_MIN = 2;
    localparam int FIFO_PTR_MAX_W       = 32;

    typedef logic [FIFO_PTR_MAX_W-1:0] fifo_word_t;

    function automatic fifo_word_t bin2gray(input fifo_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Zero-extended upper bits leave the result unchanged, so any width up to the max fits.
    function automatic fifo_word_t gray2bin(input fifo_word_t gray);
        fifo_word_t bin;
        bin = '0;
        for (int i = 0; i < FIFO_PTR_MAX_W; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// N-stage flop synchroniser for a Gray-coded bus; asynchronous active-high reset clears every stage.
module gray_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;

    // Pure shift chain: nothing sits between stages.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rptr_empty.sv
// Read-side pointer, empty flag and fill count of the async FIFO (write pointer synchronised into rd_clk_i).
// Define ASYNC_FIFO_AEMPTY_EN to add the registered almost-empty output rd_aempty_o.
module rptr_empty
    import async_fifo_pkg::*;
#(
    parameter int PTR_WIDTH   = 5,
    parameter int SYNC_STAGES = 2,
    parameter int AEMPTY_TH   = 2
) (
    input  logic                 rd_clk_i,
    input  logic                 rst_i,
    input  logic                 rd_en_i,
    input  logic [PTR_WIDTH:0]   wptr_gray_i,
    output logic [PTR_WIDTH:0]   rptr_gray_o,
    output logic [PTR_WIDTH-1:0] rd_addr_o,
    output logic                 rd_empty_o,
    output logic [PTR_WIDTH:0]   rd_cnt_o
`ifdef ASYNC_FIFO_AEMPTY_EN
    ,
    output logic                 rd_aempty_o
`endif
);

    typedef logic [PTR_WIDTH:0] ptr_t;

    if (SYNC_STAGES < FIFO_SYNC_STAGES_MIN || SYNC_STAGES > 3 || AEMPTY_TH < 0) begin : g_bad_cfg
        $error("rptr_empty: illegal parameter value");
    end

    ptr_t wptr_gray_s;
    ptr_t rptr_bin_q,  rptr_bin_d;
    ptr_t rptr_gray_q, rptr_gray_d;
    ptr_t rd_cnt_q,    rd_cnt_d;
    logic rd_empty_q,  rd_empty_d;
    logic rd_ok;

    gray_sync #(
        .WIDTH  (PTR_WIDTH + 1),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk_i (rd_clk_i),
        .rst_i (rst_i),
        .d_i   (wptr_gray_i),
        .q_o   (wptr_gray_s)
    );

    // Read advance and the newly synchronised write pointer both feed the same _d values.
    always_comb begin
        rd_ok       = rd_en_i & ~rd_empty_q;
        rptr_bin_d  = rptr_bin_q + ptr_t'(rd_ok);
        rptr_gray_d = ptr_t'(bin2gray(fifo_word_t'(rptr_bin_d)));
        rd_empty_d  = (rptr_gray_d == wptr_gray_s);
        rd_cnt_d    = ptr_t'(gray2bin(fifo_word_t'(wptr_gray_s))) - rptr_bin_d;
    end

    always_ff @(posedge rd_clk_i or posedge rst_i) begin
        if (rst_i) begin
            rptr_bin_q  <= '0;
            rptr_gray_q <= '0;
            rd_empty_q  <= 1'b1;
            rd_cnt_q    <= '0;
        end else begin
            rptr_bin_q  <= rptr_bin_d;
            rptr_gray_q <= rptr_gray_d;
            rd_empty_q  <= rd_empty_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    assign rptr_gray_o = rptr_gray_q;
    assign rd_addr_o   = rptr_bin_q[PTR_WIDTH-1:0];
    assign rd_empty_o  = rd_empty_q;
    assign rd_cnt_o    = rd_cnt_q;

`ifdef ASYNC_FIFO_AEMPTY_EN
    localparam ptr_t AEMPTY_TH_P = ptr_t'(AEMPTY_TH);

    logic rd_aempty_q, rd_aempty_d;

    always_comb begin
        rd_aempty_d = (rd_cnt_d <= AEMPTY_TH_P);
    end

    always_ff @(posedge rd_clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_aempty_q <= 1'b1;
        end else begin
            rd_aempty_q <= rd_aempty_d;
        end
    end

    assign rd_aempty_o = rd_aempty_q;
`endif

endmodule

// File: tb/tb_rptr_empty.sv
// Randomised scoreboard bench for rptr_empty (PTR_WIDTH=5, SYNC_STAGES=2); wptr_gray_i driven directly.
module tb_rptr_empty;

    localparam int PW = 5;
`ifdef ASYNC_FIFO_AEMPTY_EN
    localparam int EW = 19;
`else
    localparam int EW = 18;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rd_en = 1'b0;
    logic [PW:0]   wptr_gray = '0;
    logic [PW:0]   rptr_gray;
    logic [PW-1:0] rd_addr;
    logic          rd_empty;
    logic [PW:0]   rd_cnt;
`ifdef ASYNC_FIFO_AEMPTY_EN
    logic          rd_aempty;
`endif

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_q[$];

    // Reference model: true read/write counts, write visibility delayed two cycles.
    int   m_r = 0;
    int   m_hist0 = 0;
    int   m_hist1 = 0;
    bit   m_empty = 1'b1;
    logic [PW:0] prev_gray = '0;

    always #5 clk = ~clk;

    rptr_empty #(
        .PTR_WIDTH   (PW),
        .SYNC_STAGES (2),
        .AEMPTY_TH   (2)
    ) dut (
        .rd_clk_i    (clk),
        .rst_i       (rst),
        .rd_en_i     (rd_en),
        .wptr_gray_i (wptr_gray),
        .rptr_gray_o (rptr_gray),
        .rd_addr_o   (rd_addr),
        .rd_empty_o  (rd_empty),
        .rd_cnt_o    (rd_cnt)
`ifdef ASYNC_FIFO_AEMPTY_EN
        ,
        .rd_aempty_o (rd_aempty)
`endif
    );

    function automatic logic [PW:0] to_gray(input int n);
        logic [PW:0] v;
        v = PW'(0);
        v = (PW+1)'(n % 64);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One rd clock cycle: drive at the falling edge, push the expected post-edge outputs.
    task automatic step(input bit rd, input int w);
        int  wvis;
        int  cnt;
        logic [EW-1:0] e;
        @(negedge clk);
        rd_en     = rd;
        wptr_gray = to_gray(w);
        if (rd && !m_empty) m_r++;
        wvis    = m_hist1;
        m_hist1 = m_hist0;
        m_hist0 = w;
        cnt     = wvis - m_r;
        m_empty = (cnt == 0);
`ifdef ASYNC_FIFO_AEMPTY_EN
        e = {m_empty, 6'(cnt), to_gray(m_r), 5'(m_r % 32), (cnt <= 2)};
`else
        e = {m_empty, 6'(cnt), to_gray(m_r), 5'(m_r % 32)};
`endif
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_empty"}, int'(rd_empty), 1);
        chk({tag, "_cnt"},   int'(rd_cnt), 0);
        chk({tag, "_gray"},  int'(rptr_gray), 0);
        chk({tag, "_addr"},  int'(rd_addr), 0);
`ifdef ASYNC_FIFO_AEMPTY_EN
        chk({tag, "_aempty"}, int'(rd_aempty), 1);
`endif
    endtask

    // Called right after an active edge; reset is pulsed and checked while clk is high.
    task automatic reset_pulse();
        #2;
        rst = 1'b1;
        m_r = 0; m_hist0 = 0; m_hist1 = 0; m_empty = 1'b1;
        #1;
        check_reset_values("mid_reset");
        prev_gray = '0;
        rst = 1'b0;
    endtask

    // Monitor: compares every presented output against the scoreboard head.
    always begin
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
`ifdef ASYNC_FIFO_AEMPTY_EN
            a = {rd_empty, rd_cnt, rptr_gray, rd_addr, rd_aempty};
`else
            a = {rd_empty, rd_cnt, rptr_gray, rd_addr};
`endif
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs{empty,cnt,gray,addr}: got %h expected %h at %0t", a, e, $time);
            end
            checks++;
            if ($countones(rptr_gray ^ prev_gray) > 1) begin
                errors++;
                $display("FAIL gray_step: got %h after %h at %0t", rptr_gray, prev_gray, $time);
            end
            prev_gray = rptr_gray;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("init_reset");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Single write becomes visible on the third edge.
        for (int i = 0; i < 4; i++) step(1'b0, 1);
        // One read drains it; further requests while empty are ignored.
        for (int i = 0; i < 6; i++) step(1'b1, 1);
        // Fill to 7 entries, then reset mid-stream.
        for (int k = 2; k <= 8; k++) step(1'b0, k);
        for (int i = 0; i < 3; i++) step(1'b0, 8);
        reset_pulse();

        // Full FIFO then 32 back-to-back reads across the address wrap.
        for (int i = 0; i < 3; i++) step(1'b0, 32);
        for (int i = 0; i < 32; i++) step(1'b1, 32);

        // Random monotonic writes (at most one step per cycle) and random read requests.
        w = 32;
        for (int i = 0; i < 200; i++) begin
            bit rd;
            rd = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) != 0 && (w - m_r) < 32) w++;
            step(rd, w);
        end

        // Drain to empty so the count walks down through the almost-empty threshold.
        for (int i = 0; i < 40; i++) step(1'b1, w);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
